cve2_multdiv_arbiter: RTL

Two-requester arbiter and sequencer for the shared `cve2_multdiv_fast` unit. It accepts RV32M operations from requester 0 (core ID stage) and requester 1 (auxiliary/coprocessor port) and latches their operands. It drives the multiplier/divider enables and selects for the full multi-cycle operation, and returns each result to the requester that issued it. Grants are round-robin and locked for the whole operation, because the unit keeps intermediate state in its `imd_val` registers.

---
 rtl/cve2_multdiv_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cve2_multdiv_arbiter.sv
// -----------------------------------------------------------------------------
// cve2_multdiv_arbiter
//
// Purpose:
//   Shares one cve2_multdiv_fast unit between two requesters (0 = core ID
//   stage, 1 = auxiliary/coprocessor port). A grant is given round-robin from
//   IDLE and is held for the whole multi-cycle operation, because the unit
//   keeps intermediate state in its imd_val registers. The result is held in
//   a response register until the owning requester consumes it.
//
//   All outputs are registered. They are computed from the next-state values,
//   so each output lines up with the state it belongs to. The accept pulse on
//   req_ready_o therefore appears in the first BUSY cycle.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i[r]           requester r has an operation pending
//   req_ready_o[r]           one-cycle accept pulse toward requester r
//   req_operator_i[r]        0 MUL, 1 MULH, 2 DIV, 3 REM
//   req_signed_mode_i[r]     bit0 op_a signed, bit1 op_b signed
//   req_op_a_i/_b_i[r]       operands of requester r
//   rsp_valid_o[r]           result pending for requester r
//   rsp_result_o             shared result bus, qualified by rsp_valid_o
//   rsp_ready_i[r]           requester r consumes the result
//   mult_en_o/div_en_o       unit enables
//   mult_sel_o/div_sel_o     unit selects
//   operator_o/signed_mode_o latched operation toward the unit
//   op_a_o/op_b_o            latched operands toward the unit
//   multdiv_ready_id_o       unit never holds while an operation runs
//   valid_i/result_i         unit completion and result
//   busy_o                   operation active or response pending
//   owner_o                  requester holding the current grant
//   last_cycles_o            BUSY cycles of the last completed op (sat. 63)
// -----------------------------------------------------------------------------
module cve2_multdiv_arbiter #(
    parameter logic RESET_PRIO = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][1:0]  req_operator_i,
    input  logic [1:0][1:0]  req_signed_mode_i,
    input  logic [1:0][31:0] req_op_a_i,
    input  logic [1:0][31:0] req_op_b_i,
    output logic [1:0]       rsp_valid_o,
    output logic [31:0]      rsp_result_o,
    input  logic [1:0]       rsp_ready_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output logic [1:0]       operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    output logic             multdiv_ready_id_o,
    input  logic             valid_i,
    input  logic [31:0]      result_i,
    output logic             busy_o,
    output logic             owner_o,
    output logic [5:0]       last_cycles_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    // One-hot vector for a requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    // Requester granted most recently; the other one wins a contention.
    logic        last_q, last_d;
    logic [1:0]  operator_q, operator_d;
    logic [1:0]  signed_mode_q, signed_mode_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  last_cycles_q, last_cycles_d;

    logic [1:0]  req_ready_q, req_ready_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic        mult_en_q, mult_en_d;
    logic        div_en_q, div_en_d;
    logic        ready_id_q, ready_id_d;
    logic        busy_q, busy_d;

    logic        grant_valid_s;
    logic        grant_idx_s;
    logic [5:0]  cnt_inc_s;

    // Round-robin pick among the valid requesters.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = owner_q;
        case (req_valid_i)
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = ~last_q;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_idx_s   = owner_q;
            end
        endcase
    end

    // Saturating increment of the BUSY cycle counter.
    always_comb begin
        if (cnt_q == 6'd63) begin
            cnt_inc_s = 6'd63;
        end else begin
            cnt_inc_s = cnt_q + 6'd1;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        operator_d    = operator_q;
        signed_mode_d = signed_mode_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        result_d      = result_q;
        cnt_d         = cnt_q;
        last_cycles_d = last_cycles_q;
        req_ready_d   = 2'b00;

        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    req_ready_d   = onehot2(grant_idx_s);
                    owner_d       = grant_idx_s;
                    operator_d    = req_operator_i[grant_idx_s];
                    signed_mode_d = req_signed_mode_i[grant_idx_s];
                    op_a_d        = req_op_a_i[grant_idx_s];
                    op_b_d        = req_op_b_i[grant_idx_s];
                    cnt_d         = 6'd0;
                    state_d       = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // The cycle carrying valid_i is itself a BUSY cycle, so it
                // is included in the recorded count.
                cnt_d = cnt_inc_s;
                if (valid_i) begin
                    result_d      = result_i;
                    last_cycles_d = cnt_inc_s;
                    state_d       = RESP;
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The operator latch only changes in IDLE, so enables and selects
        // derived from it cannot change during BUSY.
        mult_en_d  = (state_d == BUSY) && !operator_d[1];
        div_en_d   = (state_d == BUSY) && operator_d[1];
        ready_id_d = (state_d == BUSY);
        busy_d     = (state_d != IDLE);
        if (state_d == RESP) begin
            rsp_valid_d = onehot2(owner_d);
        end else begin
            rsp_valid_d = 2'b00;
        end
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            owner_q       <= RESET_PRIO;
            last_q        <= ~RESET_PRIO;
            operator_q    <= 2'b00;
            signed_mode_q <= 2'b00;
            op_a_q        <= 32'd0;
            op_b_q        <= 32'd0;
            result_q      <= 32'd0;
            cnt_q         <= 6'd0;
            last_cycles_q <= 6'd0;
            req_ready_q   <= 2'b00;
            rsp_valid_q   <= 2'b00;
            mult_en_q     <= 1'b0;
            div_en_q      <= 1'b0;
            ready_id_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            operator_q    <= operator_d;
            signed_mode_q <= signed_mode_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            result_q      <= result_d;
            cnt_q         <= cnt_d;
            last_cycles_q <= last_cycles_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            mult_en_q     <= mult_en_d;
            div_en_q      <= div_en_d;
            ready_id_q    <= ready_id_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready_o        = req_ready_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_result_o       = result_q;
    assign mult_en_o          = mult_en_q;
    assign mult_sel_o         = mult_en_q;
    assign div_en_o           = div_en_q;
    assign div_sel_o          = div_en_q;
    assign operator_o         = operator_q;
    assign signed_mode_o      = signed_mode_q;
    assign op_a_o             = op_a_q;
    assign op_b_o             = op_b_q;
    assign multdiv_ready_id_o = ready_id_q;
    assign busy_o             = busy_q;
    assign owner_o            = owner_q;
    assign last_cycles_o      = last_cycles_q;

endmodule
